// File: rtl/cyclic74_pkg.sv
// Shared constants and types for the (7,4) cyclic encoder, g(x) = 1 + x + x^3.
// The x^3 term of g(x) is implicit; G_LO carries {g2,g1,g0}.
package cyclic74_pkg;

  localparam int N     = 7;
  localparam int K     = 4;
  localparam int R     = 3;
  localparam int CNT_W = 3;

  localparam logic [R-1:0] G_LO_DEFAULT = 3'b011;

  // Last counter value of the message phase and of the whole word.
  localparam logic [CNT_W-1:0] CNT_MSG_LAST = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/cyclic74_lfsr.sv
// Serial 3-stage Galois LFSR dividing by g(x); the remainder is left in r.
// With gate_fb low the register just shifts toward r[2], draining the parity.
module cyclic74_lfsr
  import cyclic74_pkg::*;
#(
  parameter logic [R-1:0] G_LO = G_LO_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  input  logic         gate_fb,
  output logic [R-1:0] r
);

  logic fb;

  assign fb = gate_fb & (din ^ r[2]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r <= '0;
    end else if (clr) begin
      r <= '0;
    end else if (en) begin
      r <= {r[1] ^ (G_LO[2] & fb), r[0] ^ (G_LO[1] & fb), G_LO[0] & fb};
    end
  end

endmodule

// File: rtl/cyclic74_enc_ctrl.sv
// Sequencer for the serial (7,4) cyclic encoder: accepts a message word,
// streams the systematic codeword c6 first, then holds it in parallel.
//
// state | meaning
// IDLE  | in_ready=1, waiting for in_valid
// SHIFT | 7 cycles: cnt 0..3 message bits, cnt 4..6 parity bits
// HOLD  | out_valid=1 until out_ready
module cyclic74_enc_ctrl
  import cyclic74_pkg::*;
#(
  parameter logic [R-1:0] G_LO = G_LO_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] data_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [K-1:0]     msg_q;
  logic [N-1:0]     cw_q;
  logic [N-1:0]     data_out_q;
  logic [R-1:0]     lfsr_r;

  logic accept;
  logic shifting;
  logic msg_phase;
  logic last_bit;
  logic ser_bit;

  assign accept    = (state_q == IDLE) && in_valid;
  assign shifting  = (state_q == SHIFT);
  assign msg_phase = (cnt_q <= CNT_MSG_LAST);
  assign last_bit  = (cnt_q == CNT_LAST);

  // m[3-cnt] for cnt 0..3 is the bitwise complement of cnt[1:0].
  always_comb begin
    ser_bit = 1'b0;
    if (shifting) begin
      if (msg_phase) begin
        ser_bit = msg_q[~cnt_q[1:0]];
      end else begin
        ser_bit = lfsr_r[R-1];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      msg_q      <= '0;
      cw_q       <= '0;
      data_out_q <= '0;
    end else begin
      if (accept) begin
        msg_q <= data_in;
        cnt_q <= '0;
      end else if (shifting) begin
        cnt_q <= cnt_q + CNT_W'(1);
        cw_q  <= {cw_q[N-2:0], ser_bit};
        // data_out only changes when a complete codeword lands.
        if (last_bit) begin
          data_out_q <= {cw_q[N-2:0], ser_bit};
        end
      end
    end
  end

  cyclic74_lfsr #(
    .G_LO(G_LO)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (shifting),
    .din    (ser_bit),
    .gate_fb(msg_phase),
    .r      (lfsr_r)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign ser_valid = shifting;
  assign ser_out   = ser_bit;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_cyclic74_enc_ctrl.sv
// Scoreboard bench for cyclic74_enc_ctrl: expected codewords and serial bits
// are queued at stimulus time and checked as the DUT produces them.
module tb_cyclic74_enc_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_in;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [6:0] cw_q[$];
  logic       ser_q[$];

  cyclic74_enc_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_out (data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Polynomial long division of m(x)*x^3 by x^3+x+1.
  function automatic logic [6:0] model_cw(input logic [3:0] m);
    logic [6:0] v;
    logic [6:0] g;
    v = {m, 3'b000};
    g = 7'b0001011;
    for (int i = 6; i >= 3; i--) begin
      if (v[i]) v = v ^ (g << (i - 3));
    end
    return {m, v[2:0]};
  endfunction

  // Monitor: inputs change just after posedge, so negedge sees a stable cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ser_valid) begin
        if (ser_q.size() == 0) chk("ser_unexpected", 32'(ser_out), 32'hx);
        else chk("ser_bit", 32'(ser_out), 32'(ser_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (cw_q.size() == 0) chk("cw_unexpected", 32'(data_out), 32'hx);
        else chk("codeword", 32'(data_out), 32'(cw_q.pop_front()));
      end
    end
  end

  task automatic send_word(input logic [3:0] m, input logic [6:0] exp, input bit keep,
                           output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    data_in  = m;
    in_valid = 1'b1;
    cw_q.push_back(exp);
    for (int b = 6; b >= 0; b--) ser_q.push_back(exp[b]);
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((cw_q.size() != 0 || ser_q.size() != 0 || !in_ready) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(cw_q.size() + ser_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc_t[4];
    int n;
    logic [3:0] seq_m[4];
    logic [6:0] seq_c[4];
    logic [6:0] bp_exp;

    seq_m = '{4'b1001, 4'b0011, 4'b0001, 4'b1111};
    seq_c = '{7'b1001110, 7'b0011101, 7'b0001011, 7'b1111111};

    rst_n = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ser_valid", 32'(ser_valid), 32'd0);
    chk("rst_data_out",  32'(data_out),  32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word, serial stream 1,0,1,0,0,1,1
    send_word(4'b1010, 7'b1010011, 1'b0, acc);
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t1_ready_return", 32'(n), 32'd8);
    chk("t1_data_out", 32'(data_out), 32'(7'b1010011));
    wait_drain();

    // Back-to-back words with in_valid held high
    for (int i = 0; i < 4; i++) begin
      send_word(seq_m[i], seq_c[i], i < 3, acc);
      acc_t[i] = acc;
    end
    for (int i = 1; i < 4; i++) chk("seq_period", 32'(acc_t[i] - acc_t[i-1]), 32'd9);
    wait_drain();

    // Back-pressure in HOLD
    out_ready = 1'b0;
    bp_exp = model_cw(4'b0110);
    send_word(4'b0110, bp_exp, 1'b0, acc);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_latency", 32'(n), 32'd7);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; data_in = 4'b1111;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_data_out",  32'(data_out),  32'(bp_exp));
      chk("bp_in_ready",  32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready),  32'd1);
    chk("bp_data_kept",     32'(data_out),  32'(bp_exp));
    wait_drain();

    // Reset in the middle of a word at cnt=3
    send_word(4'b1010, 7'b1010011, 1'b0, acc);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    cw_q.delete();
    ser_q.delete();
    @(posedge clk); #1;
    chk("mr_data_out",  32'(data_out),  32'd0);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_ser_valid", 32'(ser_valid), 32'd0);
    chk("mr_ser_out",   32'(ser_out),   32'd0);
    chk("mr_busy",      32'(busy),      32'd0);
    chk("mr_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    send_word(4'b0001, 7'b0001011, 1'b0, acc);
    wait_drain();

    // Exhaustive sweep against the division model
    for (int m = 0; m < 16; m++) send_word(4'(m), model_cw(4'(m)), 1'b0, acc);
    wait_drain();

    // in_valid pulsed during SHIFT must not start another word
    send_word(4'b0101, model_cw(4'b0101), 1'b0, acc);
    n = 1;
    for (int k = 1; k < 20; k++) begin
      if (k == 2) begin in_valid = 1'b1; data_in = 4'b1111; end
      if (k == 3) in_valid = 1'b0;
      @(posedge clk); #1;
      if (!busy) break;
      n++;
    end
    chk("pulse_busy_cycles", 32'(n), 32'd8);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pulse_no_second", 32'(busy), 32'd0);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cyclic74_enc_ctrl.md
# cyclic74_enc_ctrl

Sequencer for the (7,4) cyclic code, g(x)=1+x+x^3, built around a serial 3-stage LFSR encoder. It accepts 4-bit message words over a valid/ready handshake and clocks the message MSB-first through the LFSR. It then shifts out the 3 parity bits and presents the systematic 7-bit codeword in parallel and as a serial stream. It sits between the message source and the channel/decoder front end of the codec.

## Interface
- G_LO, 3'b011: low coefficients {g2,g1,g0} of g(x); x^3 is implicit. Default gives 1+x+x^3.
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- data_in  in  4  message m3..m0; m3 is the coefficient of x^3
- in_valid  in  1  data_in valid
- in_ready  out  1  1 only in IDLE
- data_out  out  7  codeword {m3,m2,m1,m0,p2,p1,p0}; stable while out_valid
- out_valid  out  1  codeword ready (HOLD)
- out_ready  in  1  consumer accepts codeword
- ser_out  out  1  serial codeword bit, c6 first
- ser_valid  out  1  ser_out meaningful (SHIFT state)
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: in_ready=1. in_valid=1 latches data_in, clears LFSR, sets cnt=0, goes to SHIFT.
  - SHIFT: 7 cycles, cnt 0..6.
  - HOLD: out_valid=1 until out_ready.
- SHIFT, cnt 0..3 (message phase):
  - ser_out = m[3-cnt]
  - fb = ser_out ^ r2; r2<=r1^(g2&fb); r1<=r0^(g1&fb); r0<=g0&fb
- SHIFT, cnt 4..6 (parity phase):
  - ser_out = r2; LFSR shifts with fb forced 0 (r2<=r1, r1<=r0, r0<=0)
- Every SHIFT edge shifts ser_out into a 7-bit codeword register. The edge with cnt==6 goes to HOLD, and the register then holds c6..c0.
- Parity equals m(x)·x^3 mod g(x). Result is systematic, parity in the low bits.
- HOLD: out_ready=1 goes to IDLE. data_out keeps its value until the next codeword completes. out_valid drops to 0.
- in_valid is ignored outside IDLE. A word arriving during SHIFT/HOLD is not lost; the source must hold it until in_ready.
- out_ready is ignored outside HOLD.
- Reset (rst_n=0 at an edge), any state including mid-SHIFT:
  - goes to IDLE; partial word discarded
  - LFSR, cnt, codeword register and data_out cleared to 0
  - out_valid=0, ser_valid=0, ser_out=0, busy=0, in_ready=1
- No combinational path from in_valid/out_ready to in_ready/out_valid. All outputs are decoded from registers.

## Timing
- Accept edge E0 (IDLE, in_valid=1). ser_valid=1 and ser_out=m3 in the cycle after E0.
- Serial bit k (k=0..6) is presented in the cycle after edge Ek.
- out_valid rises after E7, giving a latency of 7 cycles from acceptance.
- If out_ready is already 1, the codeword is consumed at E8 and in_ready returns at E8. The next accept is at E9.
- Minimum word period is 9 cycles. HOLD back-pressure extends it one cycle per stalled cycle.
- Simultaneous rst_n=0 and any handshake: reset wins.

## Structure
- Package cyclic74_pkg:
  - N=7, K=4, R=3
  - default G_LO=3'b011
  - state enum {IDLE, SHIFT, HOLD}
  - cnt width 3
- Sub-module cyclic74_lfsr (R-bit Galois LFSR). Inputs: clk, rst_n, clr, en, din, gate_fb. Output: r[2:0].
- The controller owns the FSM, counter, message register and codeword register.

## Test plan
- Reset then single word: data_in=4'b1010, out_ready=1. Required: data_out=7'b1010011 after E7; serial stream 1,0,1,0,0,1,1; in_ready returns at E8.
- Sequence 1001, 0011, 0001, 1111 with in_valid held high. Required: 7'b1001110, 7'b0011101, 7'b0001011, 7'b1111111, one word per 9 cycles.
- Back-pressure: out_ready=0 for 5 cycles in HOLD. Required: out_valid and data_out stable, in_ready=0, new in_valid ignored; completes one edge after out_ready=1.
- Mid-operation reset: rst_n=0 at cnt=3 of word 1010. Required: all outputs 0, in_ready=1 on the next cycle; the next word 0001 yields 7'b0001011 (no residue).
- Message 0000: data_out=7'b0000000 and out_valid asserted. Exhaustive 16-word sweep matches the software model m·x^3 mod g.
- in_valid pulsed during SHIFT: no second acceptance; busy=1 for exactly 8 cycles with out_ready=1.
